// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/control-flow bundle between the core and the PC sequencer
//
// Signals:
//   stall           core -> seq   hold pc, stack and error flags for this cycle
//   instruction     core -> seq   19-bit word read combinationally at pc
//   zero_flag       core -> seq   registered ALU zero flag
//   carry_flag      core -> seq   registered ALU carry flag
//   pc              seq  -> core  registered fetch address
//   stack_level     seq  -> core  number of valid return-stack entries
//   stack_overflow  seq  -> core  sticky, JSB issued while stack full
//   stack_underflow seq  -> core  sticky, RTS issued while stack empty
// Modports: master = core side, slave = sequencer side.

interface pc_sequencer_if #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 8
);
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    logic                 stall;
    logic [18:0]          instruction;
    logic                 zero_flag;
    logic                 carry_flag;
    logic [ADDR_W-1:0]    pc;
    logic [LVL_W-1:0]     stack_level;
    logic                 stack_overflow;
    logic                 stack_underflow;

    modport master (
        output stall,
        output instruction,
        output zero_flag,
        output carry_flag,
        input  pc,
        input  stack_level,
        input  stack_overflow,
        input  stack_underflow
    );

    modport slave (
        input  stall,
        input  instruction,
        input  zero_flag,
        input  carry_flag,
        output pc,
        output stack_level,
        output stack_overflow,
        output stack_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and control-flow sequencer with hardware return stack
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (wins over stall)
//   bus   pc_sequencer_if.slave: stall/instruction/flags in, pc/stack status out
//
// Decoded opcodes (all others advance pc by one):
//   BRANCH [18:16]=101    cond [15:14] (Z, NZ, C, NC), signed offset [7:0]
//   JMP    [18:14]=11100  target [11:0]
//   JSB    [18:14]=11101  push pc+1, target [11:0]
//   RTS    [18:13]=111100 pop into pc

module pc_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    pc_sequencer_if.slave     bus
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    // Registered state
    logic [ADDR_W-1:0] r_pc;
    logic [LVL_W-1:0]  r_sp;
    logic              r_overflow;
    logic              r_underflow;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    // Decode
    logic              w_is_branch;
    logic              w_is_jmp;
    logic              w_is_jsb;
    logic              w_is_rts;
    logic [1:0]        w_cond;
    logic              w_cond_true;
    logic [7:0]        w_offset;
    logic [ADDR_W-1:0] w_offset_sext;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_branch_target;
    logic [ADDR_W-1:0] w_jump_target;

    // Stack access
    logic              w_stack_full;
    logic              w_stack_empty;
    logic [IDX_W-1:0]  w_push_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic [ADDR_W-1:0] w_top;

    // Next-state controls
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_push;
    logic              w_pop;
    logic              w_set_overflow;
    logic              w_set_underflow;
    logic              w_advance;

    // Instruction bit 12 participates in no decode; folded here so it is visibly consumed.
    logic              w_unused_bits;
    assign w_unused_bits = bus.instruction[12];

    assign w_is_branch = (bus.instruction[18:16] == 3'b101);
    assign w_is_jmp    = (bus.instruction[18:14] == 5'b11100);
    assign w_is_jsb    = (bus.instruction[18:14] == 5'b11101);
    assign w_is_rts    = (bus.instruction[18:13] == 6'b111100);

    assign w_cond   = bus.instruction[15:14];
    assign w_offset = bus.instruction[7:0];

    // Sign-extend the 8-bit offset to the PC width; all sums then wrap mod 2^ADDR_W.
    assign w_offset_sext   = {{(ADDR_W-8){w_offset[7]}}, w_offset};
    assign w_pc_inc        = r_pc + ONE;
    assign w_branch_target = w_pc_inc + w_offset_sext;
    assign w_jump_target   = ADDR_W'(bus.instruction[11:0]);

    always_comb begin
        w_cond_true = 1'b0;
        case (w_cond)
            2'b00:   w_cond_true =  bus.zero_flag;
            2'b01:   w_cond_true = ~bus.zero_flag;
            2'b10:   w_cond_true =  bus.carry_flag;
            default: w_cond_true = ~bus.carry_flag;
        endcase
    end

    // stack_level doubles as the write pointer; the top entry sits one below it.
    assign w_stack_full  = (r_sp == FULL_LVL);
    assign w_stack_empty = (r_sp == '0);
    assign w_push_idx    = r_sp[IDX_W-1:0];
    assign w_top_idx     = IDX_W'(r_sp - LVL_W'(1));
    assign w_top         = r_stack[w_top_idx];

    always_comb begin
        w_next_pc       = w_pc_inc;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_set_overflow  = 1'b0;
        w_set_underflow = 1'b0;

        if (w_is_branch) begin
            if (w_cond_true) begin
                w_next_pc = w_branch_target;
            end
        end else if (w_is_jmp) begin
            w_next_pc = w_jump_target;
        end else if (w_is_jsb) begin
            // A full stack still takes the jump; only the return address is lost.
            w_next_pc = w_jump_target;
            if (w_stack_full) begin
                w_set_overflow = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else if (w_is_rts) begin
            // An empty stack falls through to pc+1 rather than jumping to garbage.
            if (w_stack_empty) begin
                w_set_underflow = 1'b1;
            end else begin
                w_pop     = 1'b1;
                w_next_pc = w_top;
            end
        end
    end

    assign w_advance = ~bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_advance) begin
            r_pc        <= w_next_pc;
            r_overflow  <= r_overflow  | w_set_overflow;
            r_underflow <= r_underflow | w_set_underflow;
            if (w_push) begin
                r_sp <= r_sp + LVL_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - LVL_W'(1);
            end
        end
    end

    // Stack contents carry no reset; entries above the pointer are never read.
    always_ff @(posedge clk) begin
        if (!rst && w_advance && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign bus.pc              = r_pc;
    assign bus.stack_level     = r_sp;
    assign bus.stack_overflow  = r_overflow;
    assign bus.stack_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer

module tb_pc_sequencer;
    localparam int ADDR_W      = 12;
    localparam int STACK_DEPTH = 8;
    localparam logic [18:0] NOP = 19'h00000;
    localparam logic [18:0] RTS = {6'b111100, 13'h0000};

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

    pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string name;
        int    exp_pc;
        int    exp_lvl;
        logic  exp_ovf;
        logic  exp_unf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [18:0] br(input logic [1:0] cond, input logic [7:0] off);
        return {3'b101, cond, 6'b000000, off};
    endfunction

    function automatic logic [18:0] jmp(input int addr);
        logic [11:0] a;
        a = addr[11:0];
        return {5'b11100, 2'b00, a};
    endfunction

    function automatic logic [18:0] jsb(input int addr);
        logic [11:0] a;
        a = addr[11:0];
        return {5'b11101, 2'b00, a};
    endfunction

    task automatic check_val(input string nm, input string fld,
                             input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
        end
    endtask

    // Apply inputs for one cycle, then record what the DUT must show after the edge.
    task automatic step(input string nm, input logic r, input logic st,
                        input logic [18:0] ins, input logic z, input logic c,
                        input int epc, input int elvl, input logic eo, input logic eu);
        exp_t e;
        rst             = r;
        bus.stall       = st;
        bus.instruction = ins;
        bus.zero_flag   = z;
        bus.carry_flag  = c;
        @(posedge clk);
        e.name    = nm;
        e.exp_pc  = epc;
        e.exp_lvl = elvl;
        e.exp_ovf = eo;
        e.exp_unf = eu;
        sb.push_back(e);
        #1;
    endtask

    // Monitor: compares the registered outputs once per cycle, away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_val(e.name, "pc",    {20'h0, bus.pc},               e.exp_pc);
                check_val(e.name, "level", {28'h0, bus.stack_level},      e.exp_lvl);
                check_val(e.name, "ovf",   {31'h0, bus.stack_overflow},   {31'h0, e.exp_ovf});
                check_val(e.name, "unf",   {31'h0, bus.stack_underflow},  {31'h0, e.exp_unf});
            end
        end
    end

    initial begin
        int pushed[STACK_DEPTH];
        int p;
        int t;

        rst             = 1'b1;
        bus.stall       = 1'b0;
        bus.instruction = NOP;
        bus.zero_flag   = 1'b0;
        bus.carry_flag  = 1'b0;

        // Reset and sequential fetch
        step("rst0", 1, 0, NOP, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, NOP, 0, 0, 0, 0, 0, 0);
        step("seq1", 0, 0, NOP, 0, 0, 1, 0, 0, 0);
        step("seq2", 0, 0, NOP, 0, 0, 2, 0, 0, 0);
        step("seq3", 0, 0, NOP, 0, 0, 3, 0, 0, 0);
        step("seq4", 0, 0, NOP, 0, 0, 4, 0, 0, 0);

        // Conditional branches
        step("bz_nt",    0, 0, br(2'b00, 8'h06), 0, 0, 5,  0, 0, 0);
        step("jmp4",     0, 0, jmp(4),           0, 0, 4,  0, 0, 0);
        step("bz_t",     0, 0, br(2'b00, 8'h06), 1, 0, 11, 0, 0, 0);
        step("jmp7",     0, 0, jmp(7),           0, 0, 7,  0, 0, 0);
        step("bnc_t",    0, 0, br(2'b11, 8'h01), 0, 0, 9,  0, 0, 0);
        step("bnc_nt",   0, 0, br(2'b11, 8'h01), 0, 1, 10, 0, 0, 0);
        step("bnc_back", 0, 0, br(2'b11, 8'hFE), 0, 0, 9,  0, 0, 0);
        step("jmp10",    0, 0, jmp(10),          0, 0, 10, 0, 0, 0);
        step("bnz_t",    0, 0, br(2'b01, 8'h02), 0, 0, 13, 0, 0, 0);
        step("bc_t",     0, 0, br(2'b10, 8'h10), 0, 1, 30, 0, 0, 0);
        step("bc_nt",    0, 0, br(2'b10, 8'h10), 1, 0, 31, 0, 0, 0);

        // Jumps, unknown encodings, wrap
        step("jmp10b",   0, 0, jmp(10),          0, 0, 10,   0, 0, 0);
        step("jmp3",     0, 0, jmp(3),           0, 0, 3,    0, 0, 0);
        step("undef",    0, 0, 19'h7C000,        0, 0, 4,    0, 0, 0);
        step("rts_like", 0, 0, {6'b111101, 13'h0}, 0, 0, 5,  0, 0, 0);
        step("jmpfff",   0, 0, jmp(12'hFFF),     0, 0, 4095, 0, 0, 0);
        step("wrap",     0, 0, NOP,              0, 0, 0,    0, 0, 0);
        step("bneg",     0, 0, br(2'b00, 8'h80), 1, 0, 3969, 0, 0, 0);

        // Subroutines
        step("jmp14",    0, 0, jmp(14),  0, 0, 14,  0, 0, 0);
        step("jsb20",    0, 0, jsb(20),  0, 0, 20,  1, 0, 0);
        step("rts15",    0, 0, RTS,      0, 0, 15,  0, 0, 0);
        step("jsb100",   0, 0, jsb(100), 0, 0, 100, 1, 0, 0);
        step("jsb200",   0, 0, jsb(200), 0, 0, 200, 2, 0, 0);
        step("rts101",   0, 0, RTS,      0, 0, 101, 1, 0, 0);
        step("nop102",   0, 0, NOP,      0, 0, 102, 1, 0, 0);
        step("rts16",    0, 0, RTS,      0, 0, 16,  0, 0, 0);

        // Overflow: nine JSBs into an eight-deep stack
        p = 16;
        for (int i = 0; i <= STACK_DEPTH; i++) begin
            t = 500 + 100 * i;
            if (i < STACK_DEPTH) pushed[i] = p + 1;
            step("jsb_ovf", 0, 0, jsb(t), 0, 0, t,
                 (i < STACK_DEPTH) ? i + 1 : STACK_DEPTH, (i == STACK_DEPTH), 0);
            p = t;
        end
        for (int i = STACK_DEPTH - 1; i >= 0; i--) begin
            step("rts_lifo", 0, 0, RTS, 0, 0, pushed[i], i, 1, 0);
        end

        // Underflow and stickiness
        step("jmp30",     0, 0, jmp(30), 0, 0, 30, 0, 1, 0);
        step("rts_empty", 0, 0, RTS,     0, 0, 31, 0, 1, 1);
        step("sticky",    0, 0, NOP,     0, 0, 32, 0, 1, 1);

        // Stall and reset interaction
        step("jmp14s", 0, 0, jmp(14), 0, 0, 14, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step("stall_jsb", 0, 1, jsb(20), 0, 0, 14, 0, 1, 1);
        end
        step("jsb_after_stall", 0, 0, jsb(20),          0, 0, 20, 1, 1, 1);
        step("stall_br",        0, 1, br(2'b00, 8'h05), 1, 0, 20, 1, 1, 1);
        step("jsb40",           0, 0, jsb(40),          0, 0, 40, 2, 1, 1);
        step("jsb60",           0, 0, jsb(60),          0, 0, 60, 3, 1, 1);
        step("rst_stall",       1, 1, jsb(80),          0, 0, 0,  0, 0, 0);
        step("post_rst",        0, 0, NOP,              0, 0, 1,  0, 0, 0);
        step("rts_after_rst",   0, 0, RTS,              0, 0, 2,  0, 0, 1);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and control-flow sequencer for the 19-bit single-cycle core. It owns the 12-bit fetch address presented to the instruction memory. Each cycle it decodes the control-flow opcodes (conditional branch, jump, jump-to-subroutine, return) in the fetched instruction against the ALU zero/carry flags, then registers the next PC. A hardware return-address stack holds subroutine return addresses, with sticky overflow and underflow error flags.

## Interface
- ADDR_W, 12, PC/address width; all PC arithmetic is modulo 2^ADDR_W.
- STACK_DEPTH, 8, return-stack entries; must be a power of two, ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  when 1, hold PC and stack; no state change.
- instruction  in  19  instruction at the current pc, combinational from instruction memory.
- zero_flag  in  1  registered ALU zero flag.
- carry_flag  in  1  registered ALU carry flag.
- pc  out  ADDR_W  registered fetch address, wired to the instruction-memory address input.
- stack_level  out  $clog2(STACK_DEPTH)+1  number of valid return entries.
- stack_overflow  out  1  sticky; set by JSB while the stack is full.
- stack_underflow  out  1  sticky; set by RTS while the stack is empty.

## Operation
- Decode uses the bits of `instruction` listed below. All other bits are don't-care.
  - BRANCH: [18:16]=101. Condition field [15:14]: 00 = Z, 01 = NZ, 10 = C, 11 = NC. Offset [7:0] is signed 8-bit, two's complement.
    - Taken: next = pc + 1 + sext(offset).
    - Not taken: next = pc + 1.
  - JMP: [18:14]=11100. next = instruction[11:0].
  - JSB: [18:14]=11101. Push pc+1, then next = instruction[11:0].
  - RTS: [18:13]=111100. Pop, then next = popped value.
  - Any other encoding: next = pc + 1.
- Arithmetic: all sums are truncated to ADDR_W bits.
  - 4095 + 1 wraps to 0.
  - Negative offsets wrap below 0.
- Return stack: LIFO register array plus pointer; stack_level equals the pointer.
  - JSB with stack full: the jump is still taken, the push is discarded (contents unchanged), stack_overflow sets to 1.
  - RTS with stack empty: next = pc + 1, stack_level stays 0, stack_underflow sets to 1.
- Error flags are sticky; only rst clears them.
- stall=1: pc, stack contents, stack_level and error flags all hold. The instruction at pc is re-evaluated on the next unstalled cycle.
- Priority order: rst > stall > decode.

## Timing
- Reset values (rst sampled high at a clock edge): pc=0, stack_level=0, stack_overflow=0, stack_underflow=0. Stack contents are don't-care.
- Reset mid-operation, including mid-subroutine, discards all return entries.
- Reset with stall=1 still resets.
- Latency:
  - The instruction at pc is decoded in the same cycle.
  - The new pc is visible one clk after that edge.
  - Every instruction occupies exactly one cycle; there is no branch delay slot.
- Flags are sampled in the cycle the BRANCH is at pc. The flag register must already hold the result of the preceding ALU instruction.
- JSB push and the pc update occur on the same edge. RTS pop and the pc update occur on the same edge.
- The first fetch after reset release is address 0.

## Test plan
- **Reset and sequential fetch:** assert rst 2 cycles, then release; memory holds only non-control instructions.
  - Required: pc = 0, 1, 2, 3 on successive cycles.
  - Required: stack_level = 0 and both error flags = 0.
- **Conditional branches:**
  - At pc=4, BRANCH cond=00, offset=0x06, zero_flag=1 → next pc=11.
  - Same instruction with zero_flag=0 → next pc=5.
  - At pc=7, cond=11 (NC), carry_flag=0 → next pc=9.
  - At pc=10, cond=11, carry_flag=0, offset=0xFE → next pc=9.
- **Jump and wrap:**
  - JMP 0x003 at pc=10 → next pc=3.
  - JMP 0xFFF, then a non-control instruction → pc goes 4095 then 0.
  - BRANCH taken at pc=0 with offset 0x80 → next pc=3969.
- **Subroutine:**
  - JSB 20 at pc=14 → next pc=20, stack_level=1.
  - RTS at 20 → next pc=15, stack_level=0.
  - Two nested JSBs return in LIFO order.
- **Stack overflow and underflow:**
  - 9 consecutive JSBs with STACK_DEPTH=8 → 9th still jumps, stack_level stays 8, stack_overflow=1.
  - 8 RTSs then return the first 8 pushed addresses in reverse order.
  - RTS while empty at pc=30 → next pc=31, stack_underflow=1.
  - Both flags stay 1 until rst.
- **Stall and reset interaction:**
  - stall=1 for 3 cycles on a JSB at pc=14 → pc stays 14, stack_level unchanged.
  - After stall release, the JSB executes once.
  - rst asserted while stack_level=3 and stall=1 → pc=0 and stack_level=0 on the next edge.
